// File: rtl/stream_fifo_flushable.sv
// -----------------------------------------------------------------------------
// stream_fifo_flushable
//
// Purpose:
//   A small valid/ready stream FIFO that feeds one arbiter input. It is fully
//   registered between its two handshakes. A beat pushed in one cycle appears
//   on the output in the next cycle. A pop frees an entry, but inp_ready_o only
//   rises in the cycle after that. A synchronous flush discards everything
//   stored and blocks both handshakes for the cycle in which it is asserted.
//
// Parameters:
//   DATA_T  payload type carried per beat
//   DEPTH   number of storage entries (2..256, need not be a power of two)
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset of pointers and usage
//   flush_i      synchronous discard of all stored beats (beats handshakes)
//   inp_data_i   upstream payload
//   inp_valid_i  upstream valid
//   inp_ready_o  upstream ready: not full and not flushing
//   oup_data_o   payload at the read pointer
//   oup_valid_o  downstream valid: not empty and not flushing
//   oup_ready_i  downstream ready
//   usage_o      registered count of stored beats
// -----------------------------------------------------------------------------
module stream_fifo_flushable #(
    parameter type         DATA_T = logic,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  DATA_T                      inp_data_i,
    input  logic                       inp_valid_i,
    output logic                       inp_ready_o,
    output DATA_T                      oup_data_o,
    output logic                       oup_valid_o,
    input  logic                       oup_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] usage_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifndef FV_RISCY_INSERT_FV
    if (DEPTH < 2) begin : g_depth_check
        $fatal(1, "stream_fifo_flushable: DEPTH must be at least 2");
    end
`endif

    // Explicit wrap so that depths which are not a power of two never index
    // past the last entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            next_ptr = '0;
        end else begin
            next_ptr = ptr + PTR_W'(1);
        end
    endfunction

    DATA_T            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] usage_q;
    logic             push;
    logic             pop;

    // Both ready and valid depend only on the registered count and on flush.
    // That keeps the two handshakes free of any combinational path between
    // them, and it makes a full FIFO refuse a push even while it pops.
    assign inp_ready_o = (usage_q < FULL_CNT) && !flush_i;
    assign oup_valid_o = (usage_q != '0) && !flush_i;

    assign push = inp_valid_i && inp_ready_o;
    assign pop  = oup_valid_o && oup_ready_i;

    assign oup_data_o = mem_q[rd_ptr_q];
    assign usage_o    = usage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   usage_q <= usage_q + CNT_W'(1);
                2'b01:   usage_q <= usage_q - CNT_W'(1);
                default: usage_q <= usage_q;
            endcase
        end
    end

    // Storage is data only and carries no reset. Its contents do not matter
    // while oup_valid_o is low.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= inp_data_i;
        end
    end

endmodule

// File: tb/tb_stream_fifo_flushable.sv
module tb_stream_fifo_flushable;

    typedef logic [7:0] data_t;

    logic  clk;
    logic  rst;

    logic  flush4, in_valid4, in_ready4, out_valid4, out_ready4;
    data_t in_data4, out_data4;
    logic  [2:0] usage4;

    logic  flush3, in_valid3, in_ready3, out_valid3, out_ready3;
    data_t in_data3, out_data3;
    logic  [1:0] usage3;

    int    n_cmp = 0;
    int    n_bad = 0;

    data_t q4[$];
    data_t q3[$];
    int    m[2];

    stream_fifo_flushable #(.DATA_T(data_t), .DEPTH(4)) dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush4),
        .inp_data_i  (in_data4),
        .inp_valid_i (in_valid4),
        .inp_ready_o (in_ready4),
        .oup_data_o  (out_data4),
        .oup_valid_o (out_valid4),
        .oup_ready_i (out_ready4),
        .usage_o     (usage4)
    );

    stream_fifo_flushable #(.DATA_T(data_t), .DEPTH(3)) dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush3),
        .inp_data_i  (in_data3),
        .inp_valid_i (in_valid3),
        .inp_ready_o (in_ready3),
        .oup_data_o  (out_data3),
        .oup_valid_o (out_valid3),
        .oup_ready_i (out_ready3),
        .usage_o     (usage3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented beat against the scoreboard head
    // and retires it on a downstream handshake.
    always @(negedge clk) begin
        if (!rst && out_valid4) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d4_extra_beat: got %0h expected none", out_data4);
            end else begin
                chk("d4_data", 32'(out_data4), 32'(q4[0]));
                if (out_ready4) void'(q4.pop_front());
            end
        end
        if (!rst && out_valid3) begin
            if (q3.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d3_extra_beat: got %0h expected none", out_data3);
            end else begin
                chk("d3_data", 32'(out_data3), 32'(q3[0]));
                if (out_ready3) void'(q3.pop_front());
            end
        end
    end

    // One clock of stimulus on DUT u (0: depth 4, 1: depth 3). Checks the
    // handshake outputs against the occupancy model, queues accepted beats.
    task automatic step(input int u, input bit v, input data_t dat, input bit r,
                        input bit fl, output bit acc);
        int   dp;
        bit   pop;
        logic rdy_a, vld_a;
        logic [2:0] use_a;
        dp = (u == 0) ? 4 : 3;
        if (u == 0) begin
            in_valid4 = v; in_data4 = dat; out_ready4 = r; flush4 = fl;
        end else begin
            in_valid3 = v; in_data3 = dat; out_ready3 = r; flush3 = fl;
        end
        #1;
        if (u == 0) begin
            rdy_a = in_ready4; vld_a = out_valid4; use_a = usage4;
        end else begin
            rdy_a = in_ready3; vld_a = out_valid3; use_a = {1'b0, usage3};
        end
        chk($sformatf("d%0d_in_ready", dp), 32'(rdy_a), 32'((m[u] < dp) && !fl));
        chk($sformatf("d%0d_out_valid", dp), 32'(vld_a), 32'((m[u] > 0) && !fl));
        chk($sformatf("d%0d_usage", dp), 32'(use_a), 32'(m[u]));
        acc = v && (m[u] < dp) && !fl;
        pop = (m[u] > 0) && r && !fl;
        if (fl) begin
            m[u] = 0;
            if (u == 0) q4.delete(); else q3.delete();
        end else begin
            if (acc) begin
                if (u == 0) q4.push_back(dat); else q3.push_back(dat);
            end
            m[u] = m[u] + int'(acc) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int sent;
        int cyc;
        logic [15:0] rpat;

        rst = 1'b1;
        {flush4, in_valid4, out_ready4, flush3, in_valid3, out_ready3} = '0;
        in_data4 = '0;
        in_data3 = '0;
        m[0] = 0;
        m[1] = 0;
        #12;
        chk("rst_in_ready4", 32'(in_ready4), 32'd1);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        chk("rst_usage4", 32'(usage4), 32'd0);
        chk("rst_in_ready3", 32'(in_ready3), 32'd1);
        chk("rst_usage3", 32'(usage3), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to full with the sink stalled, then drain A,B,C,D.
        step(0, 1, 8'h0A, 0, 0, acc);
        step(0, 1, 8'h0B, 0, 0, acc);
        step(0, 1, 8'h0C, 0, 0, acc);
        step(0, 1, 8'h0D, 0, 0, acc);
        #1;
        chk("full_usage", 32'(usage4), 32'd4);
        chk("full_in_ready", 32'(in_ready4), 32'd0);
        chk("full_head", 32'(out_data4), 32'h0A);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0, acc);
        chk("drained_usage", 32'(usage4), 32'd0);

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < 4; i++) step(0, 1, data_t'(8'h10 + i), 0, 0, acc);
        step(0, 1, 8'hEE, 1, 0, acc);
        chk("fullpp_no_push", 32'(acc), 32'd0);
        chk("fullpp_usage", 32'(usage4), 32'd3);
        chk("fullpp_in_ready", 32'(in_ready4), 32'd1);

        // Back to two stored beats, then ten cycles of push+pop across wraps.
        step(0, 0, 8'h00, 1, 0, acc);
        chk("pp_start_usage", 32'(usage4), 32'd2);
        for (int i = 0; i < 10; i++) step(0, 1, data_t'(8'h20 + i), 1, 0, acc);
        chk("pp_end_usage", 32'(usage4), 32'd2);
        step(0, 0, 8'h00, 1, 0, acc);
        step(0, 0, 8'h00, 1, 0, acc);

        // Flush with three stored and both sides willing.
        for (int i = 0; i < 3; i++) step(0, 1, data_t'(8'h40 + i), 0, 0, acc);
        step(0, 1, 8'h55, 1, 1, acc);
        chk("flush_no_push", 32'(acc), 32'd0);
        chk("flush_usage", 32'(usage4), 32'd0);
        chk("flush_out_valid", 32'(out_valid4), 32'd0);
        step(0, 1, 8'h66, 0, 0, acc);
        step(0, 0, 8'h00, 1, 0, acc);

        // Depth 3: seven beats against a fixed irregular ready pattern.
        rpat = 16'b0110_1011_0010_1101;
        sent = 0;
        cyc  = 0;
        while ((sent < 7 || m[1] > 0) && cyc < 60) begin
            step(1, sent < 7, data_t'(8'h30 + sent), rpat[cyc % 16], 0, acc);
            if (acc) sent++;
            cyc++;
        end
        chk("d3_sent", 32'(sent), 32'd7);
        chk("d3_no_timeout", 32'(cyc < 60), 32'd1);
        chk("d3_final_usage", 32'(usage3), 32'd0);

        // Reset pulsed mid-transfer with two stored beats.
        step(0, 1, 8'h71, 0, 0, acc);
        step(0, 1, 8'h72, 0, 0, acc);
        in_valid4 = 1'b1;
        in_data4  = 8'h73;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid4), 32'd0);
        chk("arst_usage", 32'(usage4), 32'd0);
        chk("arst_in_ready", 32'(in_ready4), 32'd1);
        q4.delete();
        q3.delete();
        m[0] = 0;
        m[1] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 8'h81, 0, 0, acc);
        step(0, 1, 8'h82, 1, 0, acc);
        step(0, 0, 8'h00, 1, 0, acc);
        step(0, 0, 8'h00, 1, 0, acc);

        repeat (3) @(posedge clk);
        #1;
        chk("q4_all_out", 32'(q4.size()), 32'd0);
        chk("q3_all_out", 32'(q3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
